// File: rtl/adc_acq_scheduler_pkg.sv
// Shared state encoding and default widths for the ADC acquisition scheduler.
package adc_acq_scheduler_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam int DEF_CH_NUM            = 8;
   localparam int DEF_CH_W              = 3;
   localparam int DEF_DATA_W            = 16;
   localparam int DEF_SAMPLES_PER_FRAME = 25;
   localparam int DEF_TIMEOUT_CYC       = 2000;

endpackage

// File: rtl/adc_ch_prio_enc.sv
// Lowest-set-bit encoder over a channel mask; none is high when the mask is empty.
module adc_ch_prio_enc #(
   parameter int CH_NUM = 8,
   parameter int CH_W   = 3
) (
   input  logic [CH_NUM-1:0] mask,
   output logic [CH_W-1:0]   idx,
   output logic              none
);

   always_comb begin
      idx  = '0;
      none = 1'b1;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
         if (mask[i] && none) begin
            idx  = CH_W'(i);
            none = 1'b0;
         end
      end
   end

endmodule

// File: rtl/adc_acq_scheduler.sv
// Round-robin scheduler for one shared ADC with frame-aligned sample indexing.
// Optional ADC answer timeout is built when ADC_TIMEOUT_EN is defined.
module adc_acq_scheduler
   import adc_acq_scheduler_pkg::*;
#(
   parameter int CH_NUM            = DEF_CH_NUM,
   parameter int CH_W              = DEF_CH_W,
   parameter int DATA_W            = DEF_DATA_W,
   parameter int SAMPLES_PER_FRAME = DEF_SAMPLES_PER_FRAME,
   parameter int TIMEOUT_CYC       = DEF_TIMEOUT_CYC
) (
   input  logic                                 sys_clk_i,
   input  logic                                 rst_n_i,
   input  logic                                 enable_i,
   input  logic                                 frame_start_pulse_i,
   input  logic                                 acq_start_pulse_i,
   input  logic [CH_NUM-1:0]                    ch_mask_i,
   output logic                                 adc_req_o,
   output logic [CH_W-1:0]                      adc_ch_o,
   input  logic                                 adc_done_i,
   input  logic [DATA_W-1:0]                    adc_data_i,
   output logic                                 sample_valid_o,
   output logic [CH_W-1:0]                      sample_ch_o,
   output logic [DATA_W-1:0]                    sample_data_o,
   output logic [$clog2(SAMPLES_PER_FRAME)-1:0] sample_idx_o,
   output logic                                 frame_done_o,
   output logic                                 busy_o,
   output logic                                 overrun_o,
   output logic                                 timeout_err_o
);

   localparam int IDX_W = $clog2(SAMPLES_PER_FRAME);
   localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
`ifdef ADC_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   state_t            state;
   logic [CH_NUM-1:0] mask;
   logic [CH_NUM-1:0] mask_left;
   logic [CH_NUM-1:0] enc_in;
   logic [CH_W-1:0]   enc_idx;
   logic              enc_none;
   logic [IDX_W-1:0]  idx;
   logic              pending;
   logic [TO_W-1:0]   tmo_cnt;
   logic              tmo_hit;

   // In IDLE the encoder looks at the live mask to pick the first channel.
   assign enc_in    = (state == IDLE) ? ch_mask_i : mask;
   assign mask_left = mask & ~(CH_NUM'(1) << adc_ch_o);
   assign tmo_hit   = TMO_EN && (tmo_cnt == TO_W'(TIMEOUT_CYC - 1));

   adc_ch_prio_enc #(
      .CH_NUM (CH_NUM),
      .CH_W   (CH_W)
   ) u_enc (
      .mask (enc_in),
      .idx  (enc_idx),
      .none (enc_none)
   );

   always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state          <= IDLE;
         mask           <= '0;
         idx            <= '0;
         pending        <= 1'b0;
         tmo_cnt        <= '0;
         adc_req_o      <= 1'b0;
         adc_ch_o       <= '0;
         sample_valid_o <= 1'b0;
         sample_ch_o    <= '0;
         sample_data_o  <= '0;
         sample_idx_o   <= '0;
         frame_done_o   <= 1'b0;
         busy_o         <= 1'b0;
         overrun_o      <= 1'b0;
         timeout_err_o  <= 1'b0;
      end else begin
         sample_valid_o <= 1'b0;
         frame_done_o   <= 1'b0;
         if (!enable_i) begin
            state         <= IDLE;
            mask          <= '0;
            idx           <= '0;
            pending       <= 1'b0;
            tmo_cnt       <= '0;
            adc_req_o     <= 1'b0;
            busy_o        <= 1'b0;
            overrun_o     <= 1'b0;
            timeout_err_o <= 1'b0;
         end else begin
            if (state != IDLE && acq_start_pulse_i) overrun_o <= 1'b1;
            case (state)
               IDLE: begin
                  if (frame_start_pulse_i) idx <= '0;
                  if (acq_start_pulse_i && !enc_none) begin
                     mask      <= ch_mask_i;
                     adc_ch_o  <= enc_idx;
                     adc_req_o <= 1'b1;
                     busy_o    <= 1'b1;
                     tmo_cnt   <= '0;
                     state     <= REQ;
                  end
               end
               REQ: begin
                  if (frame_start_pulse_i) pending <= 1'b1;
                  tmo_cnt <= tmo_cnt + TO_W'(1);
                  if (adc_done_i || tmo_hit) begin
                     adc_req_o <= 1'b0;
                     mask      <= mask_left;
                     if (adc_done_i) begin
                        sample_valid_o <= 1'b1;
                        sample_ch_o    <= adc_ch_o;
                        sample_data_o  <= adc_data_i;
                        sample_idx_o   <= idx;
                     end else begin
                        timeout_err_o <= 1'b1;
                     end
                     if (mask_left != '0) begin
                        state <= GAP;
                     end else begin
                        // A frame pulse seen during the round (even on its last cycle) resyncs the index.
                        state   <= IDLE;
                        busy_o  <= 1'b0;
                        pending <= 1'b0;
                        if (pending || frame_start_pulse_i) begin
                           idx <= '0;
                        end else if (idx == IDX_W'(SAMPLES_PER_FRAME - 1)) begin
                           idx          <= '0;
                           frame_done_o <= 1'b1;
                        end else begin
                           idx <= idx + IDX_W'(1);
                        end
                     end
                  end
               end
               GAP: begin
                  if (frame_start_pulse_i) pending <= 1'b1;
                  adc_ch_o  <= enc_idx;
                  adc_req_o <= 1'b1;
                  tmo_cnt   <= '0;
                  state     <= REQ;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adc_acq_scheduler.sv
// Randomized self-checking bench for adc_acq_scheduler against a round-level reference model.
module tb_adc_acq_scheduler;

   localparam int CH_NUM = 8;
   localparam int CH_W   = 3;
   localparam int DATA_W = 16;
   localparam int SPF    = 25;
   localparam int TMO    = 50;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              enable = 1'b0;
   logic              frame = 1'b0;
   logic              acq = 1'b0;
   logic [CH_NUM-1:0] mask = '0;
   logic              done = 1'b0;
   logic [DATA_W-1:0] data = '0;

   logic              adc_req_o;
   logic [CH_W-1:0]   adc_ch_o;
   logic              sample_valid_o;
   logic [CH_W-1:0]   sample_ch_o;
   logic [DATA_W-1:0] sample_data_o;
   logic [4:0]        sample_idx_o;
   logic              frame_done_o;
   logic              busy_o;
   logic              overrun_o;
   logic              timeout_err_o;

   int n_checks = 0;
   int n_errors = 0;
   int idx_m    = 0;
   bit pend_m   = 1'b0;
   bit ovr_m    = 1'b0;

   adc_acq_scheduler #(
      .CH_NUM            (CH_NUM),
      .CH_W              (CH_W),
      .DATA_W            (DATA_W),
      .SAMPLES_PER_FRAME (SPF),
      .TIMEOUT_CYC       (TMO)
   ) dut (
      .sys_clk_i           (clk),
      .rst_n_i             (rst_n),
      .enable_i            (enable),
      .frame_start_pulse_i (frame),
      .acq_start_pulse_i   (acq),
      .ch_mask_i           (mask),
      .adc_req_o           (adc_req_o),
      .adc_ch_o            (adc_ch_o),
      .adc_done_i          (done),
      .adc_data_i          (data),
      .sample_valid_o      (sample_valid_o),
      .sample_ch_o         (sample_ch_o),
      .sample_data_o       (sample_data_o),
      .sample_idx_o        (sample_idx_o),
      .frame_done_o        (frame_done_o),
      .busy_o              (busy_o),
      .overrun_o           (overrun_o),
      .timeout_err_o       (timeout_err_o)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   // Round-level model: channels in ascending order, index advances per completed round.
   task automatic run_round(input logic [7:0] m, input int lat, input bit frame_mid,
                            input bit acq_mid, input bit frame_at_start);
      int          chans[$];
      int          l;
      bit          last;
      bit          exp_fd;
      logic [15:0] d;
      for (int i = 0; i < CH_NUM; i++) if (m[i]) chans.push_back(i);
      mask  = m;
      acq   = 1'b1;
      frame = frame_at_start;
      if (frame_at_start) idx_m = 0;
      tick;
      acq   = 1'b0;
      frame = 1'b0;
      mask  = 8'($urandom);
      pend_m = 1'b0;
      foreach (chans[k]) begin
         check("req_start", {adc_req_o, adc_ch_o}, {1'b1, 3'(chans[k])});
         l = (lat < 0) ? int'($urandom_range(1, 6)) : lat;
         for (int w = 0; w < l; w++) begin
            if (w == 0 && k == 0 && frame_mid) begin
               frame  = 1'b1;
               pend_m = 1'b1;
            end
            if (w == 0 && k == 0 && acq_mid) begin
               acq   = 1'b1;
               ovr_m = 1'b1;
            end
            tick;
            frame = 1'b0;
            acq   = 1'b0;
            check("req_hold", {adc_req_o, adc_ch_o, sample_valid_o}, {1'b1, 3'(chans[k]), 1'b0});
         end
         d    = 16'($urandom);
         data = d;
         done = 1'b1;
         tick;
         done   = 1'b0;
         last   = (k == chans.size() - 1);
         exp_fd = last && !pend_m && (idx_m == SPF - 1);
         check("sample", {sample_valid_o, sample_ch_o, sample_data_o}, {1'b1, 3'(chans[k]), d});
         check("sample_idx", 32'(sample_idx_o), idx_m);
         check("frame_done", 32'(frame_done_o), 32'(exp_fd));
         check("req_low", 32'(adc_req_o), 0);
         check("busy", 32'(busy_o), 32'(!last));
         if (!last) tick;
      end
      if (pend_m) idx_m = 0;
      else idx_m = (idx_m == SPF - 1) ? 0 : idx_m + 1;
      check("overrun", 32'(overrun_o), 32'(ovr_m));
   endtask

   initial begin
      logic [7:0] m;
      int         r;
      int         cnt;
      repeat (3) tick;
      check("reset_out", {adc_req_o, adc_ch_o, sample_valid_o, sample_ch_o, sample_idx_o,
                          frame_done_o, busy_o, overrun_o, timeout_err_o}, 0);
      check("reset_data", 32'(sample_data_o), 0);
      rst_n = 1'b1;
      tick;
      enable = 1'b1;
      tick;

      // Two channels, slow ADC.
      run_round(8'h05, 10, 1'b0, 1'b0, 1'b0);

      // Full frame on a single channel, then wrap.
      frame = 1'b1;
      tick;
      frame = 1'b0;
      idx_m = 0;
      for (int i = 0; i < SPF + 1; i++) run_round(8'h01, -1, 1'b0, 1'b0, 1'b0);

      // Frame pulse in the middle of round idx 7.
      while (idx_m != 7) run_round(8'h01, -1, 1'b0, 1'b0, 1'b0);
      run_round(8'h01, 3, 1'b1, 1'b0, 1'b0);
      run_round(8'h01, 2, 1'b0, 1'b0, 1'b0);

      // Acquisition pulse while busy: flagged, dropped.
      run_round(8'h03, 4, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick;
         check("no_extra_round", {adc_req_o, busy_o, sample_valid_o}, 0);
      end
      run_round(8'h02, 2, 1'b0, 1'b0, 1'b0);

      // Disable during ch3 request.
      mask = 8'h18;
      acq  = 1'b1;
      tick;
      acq = 1'b0;
      check("dis_req", {adc_req_o, adc_ch_o}, {1'b1, 3'd3});
      repeat (3) tick;
      enable = 1'b0;
      tick;
      check("dis_out", {adc_req_o, busy_o, sample_valid_o, frame_done_o, overrun_o}, 0);
      enable = 1'b1;
      idx_m  = 0;
      ovr_m  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         check("dis_quiet", {adc_req_o, sample_valid_o}, 0);
      end
      run_round(8'h01, 2, 1'b0, 1'b0, 1'b0);

`ifdef ADC_TIMEOUT_EN
      // Channel 1 never answers; channel 2 follows.
      mask = 8'h06;
      acq  = 1'b1;
      tick;
      acq = 1'b0;
      check("tmo_req", {adc_req_o, adc_ch_o}, {1'b1, 3'd1});
      cnt = 0;
      while (!timeout_err_o && cnt < 200) begin
         tick;
         cnt++;
      end
      check("tmo_latency", cnt, TMO);
      check("tmo_req_low", {adc_req_o, sample_valid_o}, 0);
      tick;
      check("tmo_next_req", {adc_req_o, adc_ch_o}, {1'b1, 3'd2});
      data = 16'h5a5a;
      done = 1'b1;
      tick;
      done = 1'b0;
      check("tmo_sample", {sample_valid_o, sample_ch_o, sample_data_o}, {1'b1, 3'd2, 16'h5a5a});
      check("tmo_idx", 32'(sample_idx_o), idx_m);
      check("tmo_fd", 32'(frame_done_o), 32'(idx_m == SPF - 1));
      idx_m = (idx_m == SPF - 1) ? 0 : idx_m + 1;
      check("tmo_sticky", 32'(timeout_err_o), 1);
`endif

      // Randomized rounds.
      for (int i = 0; i < 60; i++) begin
         r = int'($urandom_range(0, 9));
         m = 8'($urandom);
         if (r == 0 || m == 8'h00) begin
            mask = 8'h00;
            acq  = 1'b1;
            tick;
            acq = 1'b0;
            tick;
            check("zero_mask", {adc_req_o, busy_o}, 0);
         end else if (r == 1) begin
            frame = 1'b1;
            tick;
            frame = 1'b0;
            idx_m = 0;
         end else begin
            run_round(m, -1, ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 5) == 0));
         end
      end

`ifndef ADC_TIMEOUT_EN
      check("tmo_off", 32'(timeout_err_o), 0);
`endif
      tick;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/adc_acq_scheduler.md
# adc_acq_scheduler

Sequences one shared ADC over up to CH_NUM analog channels. Each 1 ms acquisition-start pulse from the time manager triggers one round-robin conversion round. The scheduler drives a request/done handshake to the ADC front-end and emits tagged samples, a per-frame sample index and frame-complete pulses aligned to the 25 ms frame pulse. It sits between the time-management block and the ADC interface/packetiser.

## Interface
- CH_NUM, 8, number of channels (2..16)
- CH_W, 3, channel index width, equal to $clog2(CH_NUM)
- DATA_W, 16, ADC sample width
- SAMPLES_PER_FRAME, 25, acquisition rounds per 25 ms frame
- TIMEOUT_CYC, 2000, maximum sys_clk cycles from adc_req_o to adc_done_i
- sys_clk_i  in  1  100 MHz system clock, the single clock
- rst_n_i  in  1  asynchronous active-low reset
- enable_i  in  1  run enable; low aborts and holds IDLE
- frame_start_pulse_i  in  1  one-cycle 25 ms frame pulse
- acq_start_pulse_i  in  1  one-cycle acquisition-start pulse
- ch_mask_i  in  CH_NUM  channels to convert; latched at round start
- adc_req_o  out  1  conversion request, level
- adc_ch_o  out  CH_W  channel for the current request
- adc_done_i  in  1  one-cycle conversion complete, qualified by adc_req_o
- adc_data_i  in  DATA_W  sample, valid with adc_done_i
- sample_valid_o  out  1  one-cycle sample strobe
- sample_ch_o  out  CH_W  channel tag
- sample_data_o  out  DATA_W  sample data
- sample_idx_o  out  $clog2(SAMPLES_PER_FRAME)  round index within the frame
- frame_done_o  out  1  one-cycle pulse when the last round of a frame completes
- busy_o  out  1  round in progress
- overrun_o  out  1  sticky: acq pulse arrived while busy
- timeout_err_o  out  1  sticky: ADC did not answer within TIMEOUT_CYC

## Operation
- Reset value of every output is 0. Internal state is IDLE, index is 0 and the pending frame flag is clear.
- Sticky flags clear only on reset or on a low enable_i.
- FSM states: IDLE, REQ, GAP.
- IDLE:
  - On acq_start_pulse_i with enable_i high and a nonzero ch_mask_i, latch the mask and go to REQ with the lowest set channel.
  - A zero mask starts no round and leaves the index unchanged.
- REQ:
  - adc_req_o is high and adc_ch_o is stable.
  - On adc_done_i, register the sample outputs and clear that channel's latched mask bit.
  - Go to GAP if mask bits remain; otherwise end the round.
- GAP: one cycle with adc_req_o low, then REQ with the next lowest remaining channel.
- Round end:
  - If sample_idx == SAMPLES_PER_FRAME-1, pulse frame_done_o and wrap the index to 0.
  - Otherwise increment the index. Return to IDLE.
- frame_start_pulse_i in IDLE sets the index to 0.
- frame_start_pulse_i during a round sets a pending flag. At round end the index goes to 0 instead of incrementing, and frame_done_o does not pulse.
- frame_start_pulse_i and acq_start_pulse_i in the same IDLE cycle: the index is zeroed first, and the round starts with index 0.
- acq_start_pulse_i while busy: the pulse is dropped and overrun_o is set.
- enable_i low: from any state go to IDLE next cycle. adc_req_o drops, the partial round is discarded with no increment and no frame_done_o, and the index is zeroed.

## Timing
- acq pulse at cycle t leads to adc_req_o high at t+1.
- adc_done_i at cycle d gives:
  - sample_valid_o at d+1;
  - adc_req_o low at d+1;
  - next channel's adc_req_o at d+2.
- frame_done_o coincides with the final sample_valid_o of the frame.
- Minimum round length for n channels is 2n cycles. The 1 ms period bounds n×(conversion+2) below 100 000 cycles.
- sample_idx_o is constant for all samples of one round.

## Configuration
- ADC_TIMEOUT_EN defined:
  - A counter runs in REQ. When it reaches TIMEOUT_CYC-1 it sets timeout_err_o.
  - The missing sample is skipped: no sample_valid_o, and the FSM proceeds as if done had arrived.
- ADC_TIMEOUT_EN undefined: REQ waits indefinitely, and timeout_err_o is tied to 0.

## Structure
- Shared package holds the state encoding (IDLE=0, REQ=1, GAP=2) and the default widths.
- One sub-module, adc_ch_prio_enc: a combinational lowest-set-bit encoder over the latched mask, giving the index plus a none-left flag.

## Test plan
- Mask 8'b0000_0101, ADC done 10 cycles after each req:
  - reqs on ch0 then ch2;
  - two sample_valid_o, tags 0 and 2, idx 0;
  - busy_o falls after the second sample.
- 25 rounds with mask 8'h01 and no frame pulse: idx runs 0..24, frame_done_o fires with the 25th sample, then idx 0.
- Frame pulse mid-round at idx 7: the round completes at idx 7, the next round is idx 0, and no frame_done_o.
- acq pulse while busy: overrun_o sets, no extra round, and it stays set until enable_i is low.
- enable_i low during ch3 REQ: adc_req_o low next cycle, no further samples, idx 0.
- With ADC_TIMEOUT_EN, TIMEOUT_CYC=50 and ch1 never done: timeout_err_o sets 50 cycles after the req, and ch2 is requested next.
